// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage and alu32: op codes, RV32I opcodes,
// funct7 values, the issued-bundle record and small decode helpers.
package alu_issue_stage_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SLL  = 6'd1;
  localparam logic [5:0] ALU_SLT  = 6'd2;
  localparam logic [5:0] ALU_SLTU = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_OR   = 6'd6;
  localparam logic [5:0] ALU_AND  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SUB  = 6'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_bundle_t;

  // funct3 to ALU op for the f7=0 encodings; SUB/SRA are selected by the caller.
  function automatic logic [5:0] op_from_f3(input logic [2:0] f3);
    logic [5:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_shift(input logic [5:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // alu32 shifts by the full rv2, so only the shift amount may reach it.
  function automatic logic [31:0] shamt_zext(input logic [31:0] v);
    return {27'd0, v[4:0]};
  endfunction

endpackage

// File: rtl/alu_issue_stage_reg_scoreboard.sv
// Per-register busy bits for RAW hazard detection; x0 is never busy and a
// same-edge set and clear of one register leaves it busy.
module reg_scoreboard
  import alu_issue_stage_pkg::*;
#(
  parameter int N = NREGS
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_set_en,
  input  logic [4:0] i_set_idx,
  input  logic       i_clr_en,
  input  logic [4:0] i_clr_idx,
  input  logic [4:0] i_rd_idx_a,
  input  logic [4:0] i_rd_idx_b,
  output logic       o_busy_a,
  output logic       o_busy_b
);

  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  logic [N-1:0] r_busy;
  logic [N-1:0] w_set_mask;
  logic [N-1:0] w_clr_mask;
  logic [N-1:0] w_busy_next;

  // Set and clear masks, with bit 0 forced low so x0 never reads busy.
  always_comb begin
    w_set_mask  = i_set_en ? ((ONE_HOT0 << i_set_idx) & ~ONE_HOT0) : '0;
    w_clr_mask  = i_clr_en ? ((ONE_HOT0 << i_clr_idx) & ~ONE_HOT0) : '0;
    w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  // Busy bit register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy_a = r_busy[i_rd_idx_a];
  assign o_busy_b = r_busy[i_rd_idx_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of alu32: decodes RV32I ALU instructions into an
// op/operand bundle registered one cycle later, stalling on RAW hazards.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_instr,
  input  logic [31:0] i_in_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [5:0]  o_out_op,
  output logic [31:0] o_out_rv1,
  output logic [31:0] o_out_rv2,
  output logic [4:0]  o_out_rd,
  output logic        o_out_we,
  output logic        o_out_illegal,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd
);

  logic [6:0]    w_opcode;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  logic [4:0]    w_rd;
  logic [31:0]   w_imm_i;
  logic [31:0]   w_imm_u;
  logic [5:0]    w_op;
  logic [31:0]   w_rv1;
  logic [31:0]   w_rv2;
  logic          w_legal;
  logic          w_rs1_used;
  logic          w_rs2_used;
  logic          w_busy1;
  logic          w_busy2;
  logic          w_hazard;
  logic          w_accept;
  issue_bundle_t w_bundle;
  issue_bundle_t r_out;
  logic          r_out_valid;

  assign w_opcode   = i_in_instr[6:0];
  assign w_rd       = i_in_instr[11:7];
  assign w_f3       = i_in_instr[14:12];
  assign w_f7       = i_in_instr[31:25];
  assign w_imm_i    = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
  assign w_imm_u    = {i_in_instr[31:12], 12'd0};
  assign o_rs1_addr = i_in_instr[19:15];
  assign o_rs2_addr = i_in_instr[24:20];

  // Instruction decode: op selection, operand muxing and legality.
  always_comb begin
    w_op       = ALU_ADD;
    w_rv1      = 32'd0;
    w_rv2      = 32'd0;
    w_legal    = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_rv1      = i_rs1_data;
        case (w_f7)
          F7_ZERO: begin
            w_op    = op_from_f3(w_f3);
            w_legal = 1'b1;
          end
          F7_ALT: begin
            if (w_f3 == 3'b000) begin
              w_op    = ALU_SUB;
              w_legal = 1'b1;
            end else if (w_f3 == 3'b101) begin
              w_op    = ALU_SRA;
              w_legal = 1'b1;
            end else begin
              w_op    = ALU_ADD;
              w_legal = 1'b0;
            end
          end
          default: begin
            w_op    = ALU_ADD;
            w_legal = 1'b0;
          end
        endcase
        if (is_shift(w_op)) begin
          w_rv2 = shamt_zext(i_rs2_data);
        end else begin
          w_rv2 = i_rs2_data;
        end
      end
      OPC_OP_IMM: begin
        w_rs1_used = 1'b1;
        w_rv1      = i_rs1_data;
        case (w_f3)
          3'b001: begin
            if (w_f7 == F7_ZERO) begin
              w_op    = ALU_SLL;
              w_legal = 1'b1;
            end else begin
              w_op    = ALU_ADD;
              w_legal = 1'b0;
            end
          end
          3'b101: begin
            case (w_f7)
              F7_ZERO: begin
                w_op    = ALU_SRL;
                w_legal = 1'b1;
              end
              F7_ALT: begin
                w_op    = ALU_SRA;
                w_legal = 1'b1;
              end
              default: begin
                w_op    = ALU_ADD;
                w_legal = 1'b0;
              end
            endcase
          end
          default: begin
            w_op    = op_from_f3(w_f3);
            w_legal = 1'b1;
          end
        endcase
        if (is_shift(w_op)) begin
          w_rv2 = shamt_zext(w_imm_i);
        end else begin
          w_rv2 = w_imm_i;
        end
      end
      OPC_LUI: begin
        w_rv2   = w_imm_u;
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_rv1   = i_in_pc;
        w_rv2   = w_imm_u;
        w_legal = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Illegal instructions still issue, but as a harmless zero-operand ADD.
  always_comb begin
    w_bundle    = '0;
    w_bundle.rd = w_rd;
    if (w_legal) begin
      w_bundle.op      = w_op;
      w_bundle.rv1     = w_rv1;
      w_bundle.rv2     = w_rv2;
      w_bundle.we      = (w_rd != 5'd0);
      w_bundle.illegal = 1'b0;
    end else begin
      w_bundle.op      = ALU_ADD;
      w_bundle.rv1     = 32'd0;
      w_bundle.rv2     = 32'd0;
      w_bundle.we      = 1'b0;
      w_bundle.illegal = 1'b1;
    end
  end

  reg_scoreboard #(
    .N (NREGS)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set_en   (w_accept & w_bundle.we),
    .i_set_idx  (w_rd),
    .i_clr_en   (i_wb_valid),
    .i_clr_idx  (i_wb_rd),
    .i_rd_idx_a (o_rs1_addr),
    .i_rd_idx_b (o_rs2_addr),
    .o_busy_a   (w_busy1),
    .o_busy_b   (w_busy2)
  );

  assign w_hazard   = (w_rs1_used & w_busy1) | (w_rs2_used & w_busy2);
  assign o_in_ready = ~i_reset & ~w_hazard & (~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;

  // Output bundle register: load on accept, drain on handshake, else hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_bundle;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out       <= r_out;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= r_out;
      r_out_valid <= r_out_valid;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_op      = r_out.op;
  assign o_out_rv1     = r_out.rv1;
  assign o_out_rv2     = r_out.rv2;
  assign o_out_rd      = r_out.rd;
  assign o_out_we      = r_out.we;
  assign o_out_illegal = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed table-driven bench for alu_issue_stage plus hazard, backpressure and reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [31:0] out_rv1;
  logic [31:0] out_rv2;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_instr    (in_instr),
    .i_in_pc       (in_pc),
    .o_rs1_addr    (rs1_addr),
    .o_rs2_addr    (rs2_addr),
    .i_rs1_data    (rs1_data),
    .i_rs2_data    (rs2_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_op      (out_op),
    .o_out_rv1     (out_rv1),
    .o_out_rv2     (out_rv2),
    .o_out_rd      (out_rd),
    .o_out_we      (out_we),
    .o_out_illegal (out_illegal),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [5:0]  op;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v;
    in_instr = instr;
    rs1_data = d1;
    rs2_data = d2;
  endtask

  task automatic check_out(input string tag, input logic [5:0] op, input logic [31:0] rv1,
                           input logic [31:0] rv2, input logic [4:0] rd, input logic we, input logic ill);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".op"}, 32'(out_op), 32'(op));
    check({tag, ".rv1"}, out_rv1, rv1);
    check({tag, ".rv2"}, out_rv2, rv2);
    check({tag, ".rd"}, 32'(out_rd), 32'(rd));
    check({tag, ".we"}, 32'(out_we), 32'(we));
    check({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h0, 32'd5,        32'd7,        6'd0, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0};
    vecs[1]  = '{32'h40335293, 32'h0, 32'h80000000, 32'h0,        6'd8, 32'h80000000, 32'd3,        5'd5,  1'b1, 1'b0};
    vecs[2]  = '{32'h003110B3, 32'h0, 32'h0000000F, 32'h00000021, 6'd1, 32'h0000000F, 32'd1,        5'd1,  1'b1, 1'b0};
    vecs[3]  = '{32'h123453B7, 32'h0, 32'h11111111, 32'h22222222, 6'd0, 32'd0,        32'h12345000, 5'd7,  1'b1, 1'b0};
    vecs[4]  = '{32'hABCDE497, 32'h1000, 32'h5,     32'h6,        6'd0, 32'h1000,     32'hABCDE000, 5'd9,  1'b1, 1'b0};
    vecs[5]  = '{32'h40C58533, 32'h0, 32'd10,       32'd3,        6'd9, 32'd10,       32'd3,        5'd10, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFF08413, 32'h0, 32'd100,      32'd0,        6'd0, 32'd100,      32'hFFFFFFFF, 5'd8,  1'b1, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h0, 32'h1234,     32'h5678,     6'd0, 32'd0,        32'd0,        5'd0,  1'b0, 1'b1};
    vecs[8]  = '{32'h00208033, 32'h0, 32'd4,        32'd9,        6'd0, 32'd4,        32'd9,        5'd0,  1'b0, 1'b0};
    vecs[9]  = '{32'h4020C1B3, 32'h0, 32'h77,       32'h88,       6'd0, 32'd0,        32'd0,        5'd3,  1'b0, 1'b1};
    vecs[10] = '{32'h02311213, 32'h0, 32'h77,       32'h88,       6'd0, 32'd0,        32'd0,        5'd4,  1'b0, 1'b1};
    vecs[11] = '{32'h003150B3, 32'h0, 32'hF0F0F0F0, 32'hFFFFFFE5, 6'd5, 32'hF0F0F0F0, 32'd5,        5'd1,  1'b1, 1'b0};
    vecs[12] = '{32'h0051B113, 32'h0, 32'd3,        32'd0,        6'd3, 32'd3,        32'd5,        5'd2,  1'b1, 1'b0};
    vecs[13] = '{32'h403150B3, 32'h0, 32'h80000001, 32'h0000003F, 6'd8, 32'h80000001, 32'h1F,       5'd1,  1'b1, 1'b0};
    vecs[14] = '{32'h0083F333, 32'h0, 32'hFF00FF00, 32'h0F0F0F0F, 6'd7, 32'hFF00FF00, 32'h0F0F0F0F, 5'd6,  1'b1, 1'b0};

    reset = 1'b1; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; in_pc = 32'd0;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    tick();
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.op", 32'(out_op), 32'd0);
    check("rst.rv1", out_rv1, 32'd0);
    check("rst.rv2", out_rv2, 32'd0);
    check("rst.we_ill", {30'd0, out_we, out_illegal}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);

    // Table vectors: issue, check next cycle while retiring rd, then check drain.
    for (int i = 0; i < 15; i++) begin
      tick();
      drive(1'b1, vecs[i].instr, vecs[i].d1, vecs[i].d2);
      in_pc = vecs[i].pc;
      @(negedge clk);
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("v%0d.rs1_addr", i), 32'(rs1_addr), 32'(vecs[i].instr[19:15]));
      check($sformatf("v%0d.rs2_addr", i), 32'(rs2_addr), 32'(vecs[i].instr[24:20]));
      tick();
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      wb_valid = 1'b1; wb_rd = vecs[i].rd;
      @(negedge clk);
      check_out($sformatf("v%0d", i), vecs[i].op, vecs[i].rv1, vecs[i].rv2, vecs[i].rd, vecs[i].we, vecs[i].ill);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d.drain", i), 32'(out_valid), 32'd0);
    end

    // RAW hazard on x3, released one cycle after its writeback.
    tick();
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    @(negedge clk);
    check("haz.first_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h00118233, 32'h55, 32'h66);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("haz.stall%0d", c), 32'(in_ready), 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk);
    check("haz.no_bypass", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("haz.released", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd4;
    @(negedge clk);
    check_out("haz.out", 6'd0, 32'h55, 32'h66, 5'd4, 1'b1, 1'b0);
    tick();
    wb_valid = 1'b0;

    // Set and clear of x3 on the same edge: set wins.
    drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk);
    check("sc.ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    drive(1'b1, 32'h00118233, 32'd1, 32'd2);
    @(negedge clk);
    check("sc.set_wins", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0;
    tick();

    // Backpressure: bundle held stable for three cycles, then next accepted.
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    @(negedge clk);
    check("bp.first_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 32'h123453B7, 32'hDEAD, 32'hBEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp.stall%0d", c), 32'(in_ready), 32'd0);
      check_out($sformatf("bp.hold%0d", c), 6'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.resume_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    check_out("bp.next", 6'd0, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0);

    // Reset with a bundle held and x3/x7 busy.
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst2.in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst2.valid", 32'(out_valid), 32'd0);
    check("rst2.op", 32'(out_op), 32'd0);
    check("rst2.rv2", out_rv2, 32'd0);
    check("rst2.rd_we", {26'd0, out_rd, out_we}, 32'd0);
    tick();
    drive(1'b1, 32'h00118233, 32'd1, 32'd2);
    @(negedge clk);
    check("rst2.busy_clear", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
